risc_div_sequencer: RTL and testbench
=====================================

Name: risc_div_sequencer

Overview:
- Control FSM that sequences the RISC restoring-divider datapath: operand load, shift, trial subtract, restore and quotient-bit write.
- Runs one iteration per quotient bit, counting WIDTH iterations.
- Start/busy/done handshake with the issuing pipeline stage; divide-by-zero detection.
- Controller only: remainder/quotient registers and the subtractor stay in the datapath.

Parameters:
- WIDTH, 32, operand/quotient width in bits (≥2).
- CNT_W, $clog2(WIDTH), iteration counter width (5 for WIDTH=32).

Ports:
- clk  in  1  clock; all state updates on posedge unless the optional feature is enabled.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a divide; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE with no done.
- divisor_zero  in  1  datapath flag, divisor==0; valid in LOAD.
- rem_neg  in  1  sign of trial remainder from datapath; valid in FIX.
- busy  out  1  high in LOAD, SHIFT, SUB, FIX.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  sticky error; cleared by next accepted start.
- ld_operands  out  1  datapath load strobe.
- shift_en  out  1  shift remainder:quotient left by 1.
- sub_en  out  1  perform trial subtract.
- restore_en  out  1  add divisor back.
- q_wr  out  1  write q_bit into quotient LSB.
- q_bit  out  1  quotient bit value (!rem_neg).
- iter_count  out  CNT_W  current iteration index.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, iter_count=0, all outputs 0, div_by_zero=0.
- States: IDLE, LOAD, SHIFT, SUB, FIX, DONE. Moore outputs except restore_en/q_bit, which are combinational on rem_neg in FIX.
- IDLE: start=1 → LOAD. Also clear div_by_zero and iter_count.
- LOAD: ld_operands=1.
  - divisor_zero=1 → DONE with div_by_zero set.
  - Else → SHIFT.
- SHIFT: shift_en=1 → SUB.
- SUB: sub_en=1 → FIX.
- FIX: q_wr=1; q_bit=!rem_neg; restore_en=rem_neg.
  - iter_count==WIDTH-1 → DONE, iter_count wraps to 0.
  - Else iter_count+1 → SHIFT.
- DONE: done=1, busy=0 → IDLE.
- Latency:
  - Start accepted at edge k: LOAD is cycle k+1; done is high in cycle k+2+3*WIDTH (98 for WIDTH=32, 26 for WIDTH=8).
  - Divide-by-zero: done in cycle k+2.
- Boundary rules:
  - start while busy or in DONE is ignored; no queuing.
  - start in the same cycle DONE→IDLE is not accepted; it must be held into IDLE.
  - Back-to-back throughput: one divide per 3*WIDTH+3 cycles.
  - abort=1 in any busy state → IDLE next edge. No done, iter_count=0, div_by_zero unchanged.
  - abort in IDLE/DONE has no effect; DONE still pulses.
  - abort and start together in IDLE: start wins.
  - rst_n asserted mid-operation: immediate IDLE; strobes drop asynchronously.
  - At most one of ld_operands/shift_en/sub_en/q_wr is high in any cycle.

Optional Feature:
- Macro: RISC_DIV_NEGEDGE_OUT_EN.
- Defined: all datapath strobes (ld_operands, shift_en, sub_en, restore_en, q_wr, q_bit) are re-registered on negedge clk. They appear half a cycle later, stay one full cycle wide, and hold stable across the following posedge. These registers also reset asynchronously to 0.
- Undefined: strobes are driven directly from state/rem_neg as specified above.
- busy, done, div_by_zero and iter_count are posedge-timed in both builds.

Decomposition:
- Package risc_div_pkg:
  - state typedef (enum, 3-bit encoding: IDLE=0, LOAD=1, SHIFT=2, SUB=3, FIX=4, DONE=5)
  - default WIDTH constant
  - CNT_W helper function
- Sub-module risc_div_iter_counter: CNT_W up-counter with clear, increment and terminal-count (==WIDTH-1) output, async active-low reset.

Test Plan:
- WIDTH=8, dividend 100, divisor 7, bench datapath model driving rem_neg → q_bit sequence on q_wr 0,0,0,0,1,1,1,0 (quotient 14); done at cycle 26 after start; busy high cycles 1–25.
- divisor_zero=1 at LOAD → done at cycle 2, div_by_zero=1 and held; next start with divisor 3 clears it in LOAD.
- start pulsed at cycles 5 and 10 during a busy operation → ignored; exactly one done; iter_count reaches 7 then wraps to 0.
- abort=1 in SUB of iteration 3 → IDLE next cycle, no done pulse, iter_count=0; a fresh start then completes normally in 26 cycles.
- rst_n=0 asynchronously mid-FIX → all outputs 0 before the next clk edge; state IDLE after release.
- RISC_DIV_NEGEDGE_OUT_EN defined → shift_en rises on negedge, is stable at the following posedge, and is high exactly one clock period; latency of done unchanged (26).

Source files
------------

// File: rtl/risc_div_pkg.sv
// Shared types and sizing helpers for the restoring-divider sequencer.
// State encoding is fixed so datapath debug probes can decode it directly.
package risc_div_pkg;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StShift = 3'd2,
      StSub   = 3'd3,
      StFix   = 3'd4,
      StDone  = 3'd5
   } state_e;

   localparam int unsigned DefWidth = 32;

   // Datapath strobe bundle, kept together so the optional retiming stage is one register.
   typedef struct packed {
      logic ld_operands;
      logic shift_en;
      logic sub_en;
      logic restore_en;
      logic q_wr;
      logic q_bit;
   } strobe_t;

   function automatic int unsigned cnt_width(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/risc_div_sequencer_if.sv
// Handshake and datapath-control bundle between the issuing stage/datapath (master)
// and the divider sequencer (slave).
interface risc_div_sequencer_if
   import risc_div_pkg::*;
#(
   parameter int unsigned CNT_W = cnt_width(DefWidth)
) ();

   logic             start;
   logic             abort;
   logic             divisor_zero;
   logic             rem_neg;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic             ld_operands;
   logic             shift_en;
   logic             sub_en;
   logic             restore_en;
   logic             q_wr;
   logic             q_bit;
   logic [CNT_W-1:0] iter_count;

   modport master (
      output start, abort, divisor_zero, rem_neg,
      input  busy, done, div_by_zero, ld_operands, shift_en, sub_en, restore_en, q_wr, q_bit,
             iter_count
   );

   modport slave (
      input  start, abort, divisor_zero, rem_neg,
      output busy, done, div_by_zero, ld_operands, shift_en, sub_en, restore_en, q_wr, q_bit,
             iter_count
   );

endinterface

// File: rtl/risc_div_iter_counter.sv
// Quotient-bit iteration counter: clear has priority, increment wraps to zero at the
// terminal count WIDTH-1, which is also flagged on tc.
module risc_div_iter_counter
   import risc_div_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = tc ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc    = (count_q == LastIdx);
   assign count = count_q;

endmodule

// File: rtl/risc_div_sequencer.sv
// Control FSM for the restoring divider: LOAD, then WIDTH x (SHIFT, SUB, FIX), then DONE.
// Optional macro RISC_DIV_NEGEDGE_OUT_EN retimes the datapath strobes onto negedge clk.
module risc_div_sequencer
   import risc_div_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input logic                 clk,
   input logic                 rst_n,
   risc_div_sequencer_if.slave bus
);

   state_e           state_q;
   state_e           state_d;
   strobe_t          strb;
   strobe_t          strb_out;
   logic             busy;
   logic             done;
   logic             dbz_q;
   logic             dbz_d;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             cnt_tc;
   logic [CNT_W-1:0] iter_count;

   risc_div_iter_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (iter_count),
      .tc    (cnt_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dbz_q   <= dbz_d;
      end
   end

   // Abort beats every other exit of a busy state; it never touches the sticky error.
   always_comb begin
      state_d = state_q;
      strb    = '0;
      busy    = 1'b0;
      done    = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      dbz_d   = dbz_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d = StLoad;
               cnt_clr = 1'b1;
               dbz_d   = 1'b0;
            end
         end
         StLoad: begin
            busy             = 1'b1;
            strb.ld_operands = 1'b1;
            if (bus.abort) begin
               state_d = StIdle;
               cnt_clr = 1'b1;
            end else if (bus.divisor_zero) begin
               state_d = StDone;
               dbz_d   = 1'b1;
            end else begin
               state_d = StShift;
            end
         end
         StShift: begin
            busy          = 1'b1;
            strb.shift_en = 1'b1;
            if (bus.abort) begin
               state_d = StIdle;
               cnt_clr = 1'b1;
            end else begin
               state_d = StSub;
            end
         end
         StSub: begin
            busy        = 1'b1;
            strb.sub_en = 1'b1;
            if (bus.abort) begin
               state_d = StIdle;
               cnt_clr = 1'b1;
            end else begin
               state_d = StFix;
            end
         end
         StFix: begin
            busy            = 1'b1;
            strb.q_wr       = 1'b1;
            strb.q_bit      = ~bus.rem_neg;
            strb.restore_en = bus.rem_neg;
            if (bus.abort) begin
               state_d = StIdle;
               cnt_clr = 1'b1;
            end else begin
               cnt_inc = 1'b1;
               state_d = cnt_tc ? StDone : StShift;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

`ifdef RISC_DIV_NEGEDGE_OUT_EN
   strobe_t strb_q;

   // Half-cycle retiming: strobes are held stable across the posedge the datapath uses.
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strb_q <= '0;
      end else begin
         strb_q <= strb;
      end
   end

   assign strb_out = strb_q;
`else
   assign strb_out = strb;
`endif

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.div_by_zero = dbz_q;
   assign bus.iter_count  = iter_count;
   assign bus.ld_operands = strb_out.ld_operands;
   assign bus.shift_en    = strb_out.shift_en;
   assign bus.sub_en      = strb_out.sub_en;
   assign bus.restore_en  = strb_out.restore_en;
   assign bus.q_wr        = strb_out.q_wr;
   assign bus.q_bit       = strb_out.q_bit;

endmodule

// File: tb/tb_risc_div_sequencer.sv
// Self-checking bench for risc_div_sequencer (WIDTH=8): behavioural divider datapath plus a
// cycle-position reference model, directed scenarios and randomized operations.
module tb_risc_div_sequencer;

   localparam int W    = 8;
   localparam int CW   = 3;
   localparam int MASK = (1 << W) - 1;

   logic clk;
   logic rst_n;

   risc_div_sequencer_if #(.CNT_W(CW)) bus ();

   risc_div_sequencer #(
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: position of the current operation measured in cycles since acceptance.
   bit m_active = 0;
   int m_t      = 0;
   bit m_dz     = 0;
   bit m_dbz    = 0;

   // Behavioural datapath driven by the DUT's strobes.
   int op_dividend = 0;
   int op_divisor  = 1;
   int dp_r = 0;
   int dp_q = 0;
   int dp_d = 0;
   bit l_ld, l_sh, l_sub, l_rst, l_qwr, l_qbit;

   // Observation bookkeeping.
   int         acc_cyc  = 0;
   int         last_lat = -1;
   int         done_cnt = 0;
   int         busy_cnt = 0;
   int         max_iter = 0;
   logic [7:0] qseq     = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string p);
      chk({p, "busy"},   32'(bus.busy),        0);
      chk({p, "done"},   32'(bus.done),        0);
      chk({p, "dbz"},    32'(bus.div_by_zero), 0);
      chk({p, "ld"},     32'(bus.ld_operands), 0);
      chk({p, "shift"},  32'(bus.shift_en),    0);
      chk({p, "sub"},    32'(bus.sub_en),      0);
      chk({p, "rest"},   32'(bus.restore_en),  0);
      chk({p, "q_wr"},   32'(bus.q_wr),        0);
      chk({p, "q_bit"},  32'(bus.q_bit),       0);
      chk({p, "iter"},   32'(bus.iter_count),  0);
   endtask

   // One clock cycle: datapath reacts at posedge, inputs driven, outputs compared mid-cycle.
   task automatic cycle(input bit st, input bit ab);
      int  done_t, j, e_iter;
      bit  e_busy, e_done, e_ld, e_sh, e_sub, e_fix, rn;
      @(posedge clk);
      #1;
      cyc++;
`ifdef RISC_DIV_NEGEDGE_OUT_EN
      chk("hold_ld",    32'(bus.ld_operands), 32'(l_ld));
      chk("hold_shift", 32'(bus.shift_en),    32'(l_sh));
      chk("hold_sub",   32'(bus.sub_en),      32'(l_sub));
      chk("hold_q_wr",  32'(bus.q_wr),        32'(l_qwr));
`endif
      if (l_ld) begin
         dp_r = 0;
         dp_q = op_dividend;
         dp_d = op_divisor;
      end
      if (l_sh) begin
         dp_r = dp_r * 2 + ((dp_q >> (W - 1)) & 1);
         dp_q = (dp_q << 1) & MASK;
      end
      if (l_sub) dp_r = dp_r - dp_d;
      if (l_rst) dp_r = dp_r + dp_d;
      if (l_qwr) dp_q = (dp_q & ~1) | int'(l_qbit);
      rn               = (dp_r < 0);
      bus.rem_neg      = rn;
      bus.start        = st;
      bus.abort        = ab;
      bus.divisor_zero = (op_divisor == 0);
      @(negedge clk);
      #1;

      done_t = m_dz ? 2 : 2 + 3 * W;
      {e_busy, e_done, e_ld, e_sh, e_sub, e_fix} = '0;
      e_iter = 0;
      if (m_active) begin
         e_busy = (m_t < done_t);
         e_done = (m_t == done_t);
         e_ld   = (m_t == 1);
         if (!m_dz && m_t >= 2 && m_t <= 1 + 3 * W) begin
            j      = m_t - 2;
            e_sh   = (j % 3 == 0);
            e_sub  = (j % 3 == 1);
            e_fix  = (j % 3 == 2);
            e_iter = j / 3;
         end
      end
      chk("busy",   32'(bus.busy),        32'(e_busy));
      chk("done",   32'(bus.done),        32'(e_done));
      chk("dbz",    32'(bus.div_by_zero), 32'(m_dbz));
      chk("ld",     32'(bus.ld_operands), 32'(e_ld));
      chk("shift",  32'(bus.shift_en),    32'(e_sh));
      chk("sub",    32'(bus.sub_en),      32'(e_sub));
      chk("q_wr",   32'(bus.q_wr),        32'(e_fix));
      chk("rest",   32'(bus.restore_en),  32'(e_fix && rn));
      chk("q_bit",  32'(bus.q_bit),       32'(e_fix && !rn));
      chk("iter",   32'(bus.iter_count),  32'(e_iter));
      chk("onehot", 32'(int'(bus.ld_operands) + int'(bus.shift_en) + int'(bus.sub_en)
                        + int'(bus.q_wr) <= 1), 1);
      if (e_done && !m_dz) begin
         chk("quot", 32'(dp_q), 32'(op_dividend / op_divisor));
         chk("rem",  32'(dp_r), 32'(op_dividend % op_divisor));
      end

      if (bus.done) begin
         done_cnt++;
         last_lat = cyc - acc_cyc;
      end
      if (bus.busy) busy_cnt++;
      if (bus.q_wr) qseq = {qseq[6:0], bus.q_bit};
      if (int'(bus.iter_count) > max_iter) max_iter = int'(bus.iter_count);
      l_ld   = bus.ld_operands;
      l_sh   = bus.shift_en;
      l_sub  = bus.sub_en;
      l_rst  = bus.restore_en;
      l_qwr  = bus.q_wr;
      l_qbit = bus.q_bit;

      if (!m_active) begin
         if (st) begin
            m_active = 1;
            m_t      = 1;
            m_dz     = (op_divisor == 0);
            m_dbz    = 0;
            acc_cyc  = cyc;
            qseq     = '0;
            busy_cnt = 0;
            max_iter = 0;
         end
      end else if (m_t == done_t) begin
         m_active = 0;
      end else if (ab) begin
         m_active = 0;
      end else begin
         if (m_t == 1 && m_dz) m_dbz = 1;
         m_t++;
      end
   endtask

   // Cycles 1..n after an accepted start, with optional start/abort pulses at given offsets.
   task automatic run(input int n, input int st1, input int st2, input int ab_at);
      for (int i = 1; i <= n; i++) cycle(i == st1 || i == st2, i == ab_at);
   endtask

   task automatic reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("arst_");
      bus.start = 1'b0;
      bus.abort = 1'b0;
      m_active  = 0;
      m_dbz     = 0;
      {l_ld, l_sh, l_sub, l_rst, l_qwr, l_qbit} = '0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, guard;
      rst_n            = 1'b0;
      bus.start        = 1'b0;
      bus.abort        = 1'b0;
      bus.divisor_zero = 1'b0;
      bus.rem_neg      = 1'b0;
      {l_ld, l_sh, l_sub, l_rst, l_qwr, l_qbit} = '0;
      @(posedge clk);
      #1;
      chk_all_zero("reset_");
      @(negedge clk);
      rst_n = 1'b1;
      cycle(0, 0);
      cycle(0, 1);

      // 100 / 7 with a start held into the DONE cycle (must be ignored).
      op_dividend = 100;
      op_divisor  = 7;
      d0 = done_cnt;
      cycle(1, 0);
      run(27, 26, -1, -1);
      chk("a_latency", 32'(last_lat), 26);
      chk("a_busy_cycles", 32'(busy_cnt), 25);
      chk("a_qseq", 32'(qseq), 32'h0E);
      chk("a_quot_lit", 32'(dp_q), 14);
      chk("a_rem_lit", 32'(dp_r), 2);
      chk("a_one_done", 32'(done_cnt - d0), 1);

      // Divide by zero, sticky flag, then cleared by the next accepted start.
      op_dividend = 55;
      op_divisor  = 0;
      cycle(1, 0);
      run(4, -1, -1, -1);
      chk("b_latency", 32'(last_lat), 2);
      chk("b_dbz_held", 32'(bus.div_by_zero), 1);
      op_dividend = 20;
      op_divisor  = 3;
      cycle(1, 0);
      cycle(0, 0);
      chk("b_dbz_clr", 32'(bus.div_by_zero), 0);
      run(26, -1, -1, -1);
      chk("b2_latency", 32'(last_lat), 26);

      // Starts while busy are ignored.
      op_dividend = 200;
      op_divisor  = 9;
      d0 = done_cnt;
      cycle(1, 0);
      run(28, 5, 10, -1);
      chk("c_one_done", 32'(done_cnt - d0), 1);
      chk("c_max_iter", 32'(max_iter), 7);
      chk("c_iter_wrap", 32'(bus.iter_count), 0);

      // Abort in SUB of iteration 3, then a clean divide.
      op_dividend = 77;
      op_divisor  = 5;
      d0 = done_cnt;
      cycle(1, 0);
      run(15, -1, -1, 12);
      chk("d_no_done", 32'(done_cnt - d0), 0);
      chk("d_iter", 32'(bus.iter_count), 0);
      chk("d_idle", 32'(bus.busy), 0);
      cycle(1, 0);
      run(26, -1, -1, -1);
      chk("d_latency", 32'(last_lat), 26);

      // Asynchronous reset in the middle of a FIX cycle.
      op_dividend = 50;
      op_divisor  = 6;
      cycle(1, 0);
      run(4, -1, -1, -1);
      chk("e_in_fix", 32'(bus.q_wr), 1);
      reset_mid();
      cycle(0, 0);
      chk("e_post_iter", 32'(bus.iter_count), 0);

      // Randomized operations with stray starts/aborts.
      for (int n = 0; n < 60; n++) begin
         op_dividend = int'($urandom_range(0, MASK));
         op_divisor  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MASK));
         repeat ($urandom_range(0, 2)) cycle(0, $urandom_range(0, 3) == 0);
         cycle(1, $urandom_range(0, 3) == 0);
         guard = 0;
         while ((m_active || bus.busy || bus.done) && guard < 120) begin
            cycle($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
            guard++;
         end
         chk("rand_bound", 32'(guard < 120), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
